enigma_arb: RTL and testbench
=============================

# enigma_arb

Two-port QoS arbiter with ID-conflict tracking. It merges request streams A and B (128-bit payload, 5-bit ID, 2-bit QoS) onto the single downstream port C, tagging each beat with its source. It blocks any request whose tagged ID is still outstanding downstream, replays beats the downstream side rejects with `conflict_c`, and retires IDs on `release_c`. It is the DUT driven by the enigma simulation model.

## Interface
Parameters:
- `DW`, 128, payload width
- `IW`, 5, input ID width; output ID width is `IW+1`
- `STARVE_LIMIT`, 8, consecutive lost arbitrations before forced grant (used only with the macro)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `payload_a`  in  DW  port A payload
- `id_a`  in  IW  port A ID
- `qos_a`  in  2  port A priority, 3 = highest
- `valid_a` / `ready_a`  in / out  1  port A handshake
- `payload_b`, `id_b`, `qos_b`, `valid_b` / `ready_b`  same as A, for port B
- `payload_c`  out  DW  output payload
- `id_c`  out  IW+1  `{src, id}`, with src 0 = A, 1 = B
- `qos_c`  out  2  QoS of the granted beat
- `valid_c` / `ready_c`  out / in  1  output handshake
- `conflict_c`  in  1  sampled on a C handshake; 1 = beat rejected, replay required
- `release_c`  in  1  retire one outstanding ID
- `releaseid_c`  in  IW+1  ID to retire

## Operation
- One output slot register holds `payload_c`, `id_c`, `qos_c` and `valid_c`.
- Outstanding table: 2^(IW+1) bits, indexed by tagged ID.
- Masking: a port is eligible when `valid_x=1`, `table[{src,id_x}]=0`, and the slot does not hold `{src,id_x}` with `valid_c=1`.
- Grant between eligible ports:
  - The higher `qos` wins.
  - On a tie, round-robin: the port not granted last wins. The RR pointer resets to A, so B wins the first tie.
  - The pointer updates only on an input handshake.
- Load condition: `load = !valid_c || (ready_c && !conflict_c)`.
  - `ready_x = load && grant_x`, combinational.
  - At most one of `ready_a` / `ready_b` is high in any cycle.
  - Neither is high while the slot holds a beat not yet accepted, or a beat that was just rejected.
- C handshake (`valid_c && ready_c`):
  - `conflict_c=0`: accepted. Set `table[id_c]`; the slot empties or reloads in the same edge.
  - `conflict_c=1`: rejected. Slot contents are unchanged; the same beat is re-presented next cycle with `valid_c=1`. The table is not modified.
- Release: `release_c=1` clears `table[releaseid_c]` at the next edge.
  - Releasing a clear entry has no effect.
  - Masking uses the registered table, so a released ID becomes eligible one cycle after the release.
- Source payloads are never modified.

## Timing
- Reset, asynchronous while `rst_n=0`:
  - `valid_c=0`; `payload_c`, `id_c`, `qos_c` = 0.
  - Table all zero; RR pointer = A; starvation counters = 0.
  - `ready_a` = `ready_b` = 0 while in reset.
- Reset asserted mid-operation: in-flight slot content and all outstanding IDs are discarded; no replay after reset.
- Latency: an input handshake at cycle N gives `valid_c=1` at N+1.
- Throughput: one beat per cycle when `ready_c=1`, `conflict_c=0` and IDs do not collide.
- Output stability: once `valid_c=1`, all C outputs hold until an accepted handshake.
- Simultaneous events in one cycle:
  - Accept of ID x plus release of a different ID y: both apply.
  - Release of ID x plus a masked request for x: the request stays masked this cycle and is granted next cycle.
- `conflict_c` is ignored when there is no C handshake.

## Configuration
- `ENIGMA_ARB_STARVE_EN` defined:
  - Each port keeps a saturating counter of cycles in which it was eligible but not granted while the other port was.
  - When a counter reaches `STARVE_LIMIT`, that port wins regardless of QoS.
  - The counter clears on that port's handshake.
- Undefined: pure QoS plus round-robin; counters and `STARVE_LIMIT` have no effect. A low-QoS port may starve indefinitely.

## Structure
- Package `enigma_pkg`:
  - `DW` and `IW` constants.
  - `SRC_A=1'b0`, `SRC_B=1'b1`.
  - Typedef `enigma_req_t` {payload, id, qos}.
  - Typedef `enigma_tid_t` (IW+1 bits).
- Sub-module `enigma_arb_pick`: combinational 2-way QoS / round-robin / starvation picker taking eligibility, qos and pointer and producing one-hot grants. The slot, outstanding table, pointer and counters stay in `enigma_arb`.

## Test plan
1. A qos=1 id=3 and B qos=2 id=3, both valid, `ready_c=1` → B first with `id_c=6'h23`, A next cycle with `id_c=6'h03`; both table bits set.
2. Both qos=0, IDs distinct, continuous traffic → output alternates B, A, B, A starting with B; no bubbles.
3. Accept A id=5 without release, then A presents id=5 again → `ready_a=0` and B (id=7) proceeds; after `release_c=1`, `releaseid_c=6'h05`, A id=5 is granted the following cycle.
4. Handshake with `conflict_c=1` on `id_c=6'h12` → same payload and ID re-presented next cycle; table bit 0x12 stays clear until a handshake with `conflict_c=0`.
5. `ready_c=0` for 5 cycles with `valid_c=1` → C outputs stable, `ready_a` = `ready_b` = 0; assert `rst_n=0` mid-stall → `valid_c=0` immediately, table cleared.
6. With `ENIGMA_ARB_STARVE_EN`, A qos=3 streaming and B qos=0 → B granted after exactly 8 lost arbitrations; without the macro, B is never granted.

Source files
------------

// File: rtl/enigma_pkg.sv
// enigma_pkg: shared widths, source tags and request/ID types for the enigma arbiter.
package enigma_pkg;
    localparam int DW = 128;
    localparam int IW = 5;
    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;
    typedef logic [IW:0] enigma_tid_t;
    typedef struct packed {
        logic [DW-1:0] payload;
        logic [IW-1:0] id;
        logic [1:0]    qos;
    } enigma_req_t;
endpackage

// File: rtl/enigma_arb_pick.sv
// enigma_arb_pick: 2-way picker; starvation override, then higher QoS, then round-robin.
module enigma_arb_pick
    import enigma_pkg::*;
(
    input  logic       elig_a,
    input  logic       elig_b,
    input  logic [1:0] qos_a,
    input  logic [1:0] qos_b,
    input  logic       ptr,
    input  logic       starve_a,
    input  logic       starve_b,
    output logic       grant_a,
    output logic       grant_b
);
    logic a_wins;
    // ptr holds the last granted source, so a tie goes to the other one
    assign a_wins  = (starve_a != starve_b) ? starve_a :
                     (qos_a != qos_b)       ? (qos_a > qos_b) : (ptr == SRC_B);
    assign grant_a = elig_a && (!elig_b || a_wins);
    assign grant_b = elig_b && !grant_a;
endmodule

// File: rtl/enigma_arb.sv
// enigma_arb: two-port QoS arbiter with outstanding-ID tracking and conflict replay.
// Define ENIGMA_ARB_STARVE_EN to force a grant after STARVE_LIMIT lost arbitrations.
module enigma_arb #(
    parameter int DW           = enigma_pkg::DW,
    parameter int IW           = enigma_pkg::IW,
    parameter int STARVE_LIMIT = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] payload_a,
    input  logic [IW-1:0] id_a,
    input  logic [1:0]    qos_a,
    input  logic          valid_a,
    output logic          ready_a,
    input  logic [DW-1:0] payload_b,
    input  logic [IW-1:0] id_b,
    input  logic [1:0]    qos_b,
    input  logic          valid_b,
    output logic          ready_b,
    output logic [DW-1:0] payload_c,
    output logic [IW:0]   id_c,
    output logic [1:0]    qos_c,
    output logic          valid_c,
    input  logic          ready_c,
    input  logic          conflict_c,
    input  logic          release_c,
    input  logic [IW:0]   releaseid_c
);
    import enigma_pkg::*;
    localparam int TN = 2 ** (IW + 1);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
`ifdef ENIGMA_ARB_STARVE_EN
    localparam logic STARVE_EN = 1'b1;
`else
    localparam logic STARVE_EN = 1'b0;
`endif
    logic [DW-1:0] payload_q, payload_d;
    logic [IW:0]   id_q, id_d;
    logic [1:0]    qos_q, qos_d;
    logic          valid_q, valid_d;
    logic [TN-1:0] tbl_q, tbl_d;
    logic          ptr_q, ptr_d;
    logic [CW-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic [IW:0]   tid_a, tid_b;
    logic          elig_a, elig_b, grant_a, grant_b, starve_a, starve_b;
    logic          load, accept, hs_a, hs_b;

    assign tid_a    = {SRC_A, id_a};
    assign tid_b    = {SRC_B, id_b};
    // masking sees only the registered table, so a release takes effect one cycle later
    assign elig_a   = valid_a && !tbl_q[tid_a] && !(valid_q && id_q == tid_a);
    assign elig_b   = valid_b && !tbl_q[tid_b] && !(valid_q && id_q == tid_b);
    assign accept   = valid_q && ready_c && !conflict_c;
    assign load     = !valid_q || (ready_c && !conflict_c);
    assign ready_a  = rst_n && load && grant_a;
    assign ready_b  = rst_n && load && grant_b;
    assign hs_a     = valid_a && ready_a;
    assign hs_b     = valid_b && ready_b;
    assign starve_a = STARVE_EN && cnt_a_q == LIM;
    assign starve_b = STARVE_EN && cnt_b_q == LIM;

    assign payload_c = payload_q;
    assign id_c      = id_q;
    assign qos_c     = qos_q;
    assign valid_c   = valid_q;

    enigma_arb_pick u_pick (
        .elig_a   (elig_a),
        .elig_b   (elig_b),
        .qos_a    (qos_a),
        .qos_b    (qos_b),
        .ptr      (ptr_q),
        .starve_a (starve_a),
        .starve_b (starve_b),
        .grant_a  (grant_a),
        .grant_b  (grant_b)
    );

    always_comb begin
        payload_d = hs_b ? payload_b : hs_a ? payload_a : payload_q;
        id_d      = hs_b ? tid_b : hs_a ? tid_a : id_q;
        qos_d     = hs_b ? qos_b : hs_a ? qos_a : qos_q;
        valid_d   = hs_a || hs_b || (valid_q && !accept);
        ptr_d     = hs_b ? SRC_B : hs_a ? SRC_A : ptr_q;
        cnt_a_d   = hs_a ? '0 : (elig_a && hs_b && cnt_a_q != LIM) ? cnt_a_q + CW'(1) : cnt_a_q;
        cnt_b_d   = hs_b ? '0 : (elig_b && hs_a && cnt_b_q != LIM) ? cnt_b_q + CW'(1) : cnt_b_q;
        tbl_d     = tbl_q;
        if (release_c) tbl_d[releaseid_c] = 1'b0;
        if (accept) tbl_d[id_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            payload_q <= '0;
            id_q      <= '0;
            qos_q     <= '0;
            valid_q   <= 1'b0;
            tbl_q     <= '0;
            ptr_q     <= SRC_A;
            cnt_a_q   <= '0;
            cnt_b_q   <= '0;
        end else begin
            payload_q <= payload_d;
            id_q      <= id_d;
            qos_q     <= qos_d;
            valid_q   <= valid_d;
            tbl_q     <= tbl_d;
            ptr_q     <= ptr_d;
            cnt_a_q   <= cnt_a_d;
            cnt_b_q   <= cnt_b_d;
        end
    end
endmodule

// File: tb/tb_enigma_arb.sv
// tb_enigma_arb: vector table plus scoreboard for enigma_arb, with stall/reset and starvation sequences.
module tb_enigma_arb;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] payload_a, payload_b, payload_c;
    logic [4:0]   id_a, id_b;
    logic [1:0]   qos_a, qos_b, qos_c;
    logic         valid_a, valid_b, ready_a, ready_b, valid_c, ready_c, conflict_c, release_c;
    logic [5:0]   id_c, releaseid_c;
    int           n_cmp = 0;
    int           n_bad = 0;

    typedef struct {
        bit va; bit [4:0] ia; bit [1:0] qa;
        bit vb; bit [4:0] ib; bit [1:0] qb;
        bit rc; bit cc; bit rl; bit [5:0] rid;
        bit era; bit erb;
    } vec_t;
    typedef struct { logic [5:0] id; logic [127:0] pay; logic [1:0] qos; } beat_t;
    vec_t  vecs[$];
    beat_t sb[$];

    enigma_arb dut (
        .clk(clk), .rst_n(rst_n),
        .payload_a(payload_a), .id_a(id_a), .qos_a(qos_a), .valid_a(valid_a), .ready_a(ready_a),
        .payload_b(payload_b), .id_b(id_b), .qos_b(qos_b), .valid_b(valid_b), .ready_b(ready_b),
        .payload_c(payload_c), .id_c(id_c), .qos_c(qos_c), .valid_c(valid_c), .ready_c(ready_c),
        .conflict_c(conflict_c), .release_c(release_c), .releaseid_c(releaseid_c)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic vec_t mk(bit va, bit [4:0] ia, bit [1:0] qa, bit vb, bit [4:0] ib, bit [1:0] qb,
                                bit rc, bit cc, bit rl, bit [5:0] rid, bit era, bit erb);
        vec_t v;
        v = '{va, ia, qa, vb, ib, qb, rc, cc, rl, rid, era, erb};
        return v;
    endfunction

    function automatic logic [127:0] pay_of(int idx, bit src);
        logic [15:0] tag;
        tag = src ? 16'hBBBB : 16'hAAAA;
        return {4{tag, 16'(idx)}};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit va, input bit [4:0] ia, input bit [1:0] qa, input bit vb,
                         input bit [4:0] ib, input bit [1:0] qb, input bit rc, input bit cc,
                         input bit rl, input bit [5:0] rid, input int idx);
        valid_a = va; id_a = ia; qos_a = qa; payload_a = pay_of(idx, 1'b0);
        valid_b = vb; id_b = ib; qos_b = qb; payload_b = pay_of(idx, 1'b1);
        ready_c = rc; conflict_c = cc; release_c = rl; releaseid_c = rid;
    endtask

    // sample mid-cycle: retire an accepted beat against the queue, check readies, queue new grants
    task automatic step(input bit era, input bit erb);
        beat_t b;
        #2;
        if (valid_c && ready_c && !conflict_c) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL c_beat: got unexpected id %0h expected no beat at %0t", id_c, $time);
            end else begin
                b = sb.pop_front();
                chk("c_id", 128'(id_c), 128'(b.id));
                chk("c_payload", payload_c, b.pay);
                chk("c_qos", 128'(qos_c), 128'(b.qos));
            end
        end
        chk("ready_a", 128'(ready_a), 128'(era));
        chk("ready_b", 128'(ready_b), 128'(erb));
        if (era) sb.push_back('{{1'b0, id_a}, payload_a, qos_a});
        if (erb) sb.push_back('{{1'b1, id_b}, payload_b, qos_b});
        @(negedge clk);
    endtask

    initial begin
        vec_t v;
        bit exp_b;
        bit got_b;
        int lost;
        logic [4:0] a_id;
        // tie/QoS order, table masking and re-release
        vecs.push_back(mk(1, 5'h03, 1, 1, 5'h03, 2, 1, 0, 0, 6'h00, 0, 1));
        vecs.push_back(mk(1, 5'h03, 1, 0, 5'h00, 0, 1, 0, 0, 6'h00, 1, 0));
        vecs.push_back(mk(0, 5'h00, 0, 0, 5'h00, 0, 1, 0, 0, 6'h00, 0, 0));
        vecs.push_back(mk(1, 5'h03, 0, 1, 5'h03, 0, 1, 0, 0, 6'h00, 0, 0));
        vecs.push_back(mk(1, 5'h03, 0, 1, 5'h03, 0, 1, 0, 1, 6'h23, 0, 0));
        vecs.push_back(mk(1, 5'h03, 0, 1, 5'h03, 0, 1, 0, 1, 6'h03, 0, 1));
        vecs.push_back(mk(1, 5'h03, 0, 0, 5'h00, 0, 1, 0, 0, 6'h00, 1, 0));
        vecs.push_back(mk(0, 5'h00, 0, 0, 5'h00, 0, 1, 0, 0, 6'h00, 0, 0));
        vecs.push_back(mk(0, 5'h00, 0, 0, 5'h00, 0, 1, 0, 1, 6'h23, 0, 0));
        vecs.push_back(mk(0, 5'h00, 0, 0, 5'h00, 0, 1, 0, 1, 6'h03, 0, 0));
        // round-robin streaming B, A, B, A
        vecs.push_back(mk(1, 5'h08, 0, 1, 5'h08, 0, 1, 0, 0, 6'h00, 0, 1));
        vecs.push_back(mk(1, 5'h08, 0, 1, 5'h09, 0, 1, 0, 0, 6'h00, 1, 0));
        vecs.push_back(mk(1, 5'h09, 0, 1, 5'h09, 0, 1, 0, 0, 6'h00, 0, 1));
        vecs.push_back(mk(1, 5'h09, 0, 1, 5'h0A, 0, 1, 0, 0, 6'h00, 1, 0));
        vecs.push_back(mk(0, 5'h00, 0, 0, 5'h00, 0, 1, 0, 0, 6'h00, 0, 0));
        vecs.push_back(mk(0, 5'h00, 0, 0, 5'h00, 0, 1, 0, 1, 6'h28, 0, 0));
        vecs.push_back(mk(0, 5'h00, 0, 0, 5'h00, 0, 1, 0, 1, 6'h08, 0, 0));
        vecs.push_back(mk(0, 5'h00, 0, 0, 5'h00, 0, 1, 0, 1, 6'h29, 0, 0));
        vecs.push_back(mk(0, 5'h00, 0, 0, 5'h00, 0, 1, 0, 1, 6'h09, 0, 0));
        // outstanding id 05 blocks A until released
        vecs.push_back(mk(1, 5'h05, 0, 0, 5'h00, 0, 1, 0, 0, 6'h00, 1, 0));
        vecs.push_back(mk(0, 5'h00, 0, 0, 5'h00, 0, 1, 0, 0, 6'h00, 0, 0));
        vecs.push_back(mk(1, 5'h05, 0, 1, 5'h07, 0, 1, 0, 0, 6'h00, 0, 1));
        vecs.push_back(mk(1, 5'h05, 0, 0, 5'h00, 0, 1, 0, 1, 6'h05, 0, 0));
        vecs.push_back(mk(1, 5'h05, 0, 0, 5'h00, 0, 1, 0, 0, 6'h00, 1, 0));
        vecs.push_back(mk(0, 5'h00, 0, 0, 5'h00, 0, 1, 0, 0, 6'h00, 0, 0));
        vecs.push_back(mk(0, 5'h00, 0, 0, 5'h00, 0, 1, 0, 1, 6'h27, 0, 0));
        vecs.push_back(mk(0, 5'h00, 0, 0, 5'h00, 0, 1, 0, 1, 6'h05, 0, 0));
        // conflict replay of 12; conflict without handshake is ignored
        vecs.push_back(mk(1, 5'h12, 0, 0, 5'h00, 0, 1, 0, 0, 6'h00, 1, 0));
        vecs.push_back(mk(0, 5'h00, 0, 0, 5'h00, 0, 0, 1, 0, 6'h00, 0, 0));
        vecs.push_back(mk(0, 5'h00, 0, 1, 5'h0B, 0, 1, 1, 0, 6'h00, 0, 0));
        vecs.push_back(mk(0, 5'h00, 0, 1, 5'h0B, 0, 1, 0, 0, 6'h00, 0, 1));
        vecs.push_back(mk(0, 5'h00, 0, 0, 5'h00, 0, 1, 0, 0, 6'h00, 0, 0));
        vecs.push_back(mk(0, 5'h00, 0, 0, 5'h00, 0, 1, 0, 1, 6'h12, 0, 0));
        vecs.push_back(mk(0, 5'h00, 0, 0, 5'h00, 0, 1, 0, 1, 6'h2B, 0, 0));

        rst_n = 1'b0;
        drive(1, 5'h01, 3, 1, 5'h02, 3, 1, 0, 0, 6'h00, 0);
        #7;
        chk("rst_valid_c", 128'(valid_c), 128'(0));
        chk("rst_payload_c", payload_c, 128'(0));
        chk("rst_id_c", 128'(id_c), 128'(0));
        chk("rst_qos_c", 128'(qos_c), 128'(0));
        chk("rst_ready_a", 128'(ready_a), 128'(0));
        chk("rst_ready_b", 128'(ready_b), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 6'h00, 0);
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            drive(v.va, v.ia, v.qa, v.vb, v.ib, v.qb, v.rc, v.cc, v.rl, v.rid, i);
            step(v.era, v.erb);
        end

        // stall with a held beat, then reset mid-stall
        drive(1, 5'h1E, 0, 0, 5'h00, 0, 1, 0, 0, 6'h00, 100);
        step(1, 0);
        drive(0, 5'h00, 0, 1, 5'h02, 0, 1, 0, 0, 6'h00, 101);
        step(0, 1);
        for (int k = 0; k < 5; k++) begin
            drive(1, 5'h04, 3, 1, 5'h03, 3, 0, 0, 0, 6'h00, 102 + k);
            #2;
            chk("stall_valid_c", 128'(valid_c), 128'(1));
            chk("stall_id_c", 128'(id_c), 128'(6'h22));
            chk("stall_payload_c", payload_c, pay_of(101, 1'b1));
            chk("stall_qos_c", 128'(qos_c), 128'(0));
            step(0, 0);
        end
        drive(1, 5'h04, 3, 1, 5'h03, 3, 0, 0, 0, 6'h00, 107);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid_c", 128'(valid_c), 128'(0));
        chk("midrst_id_c", 128'(id_c), 128'(0));
        chk("midrst_payload_c", payload_c, 128'(0));
        chk("midrst_ready_a", 128'(ready_a), 128'(0));
        chk("midrst_ready_b", 128'(ready_b), 128'(0));
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 5'h1E, 0, 1, 5'h03, 0, 1, 0, 0, 6'h00, 110);
        step(0, 1);
        drive(1, 5'h1E, 0, 0, 5'h00, 0, 1, 0, 0, 6'h00, 111);
        step(1, 0);
        drive(0, 5'h00, 0, 0, 5'h00, 0, 1, 0, 0, 6'h00, 112);
        step(0, 0);
        step(0, 0);

        // A at qos 3 streams new IDs against a waiting qos 0 B
        got_b = 1'b0;
        lost = 0;
        a_id = 5'h00;
        for (int k = 0; k < 20 && !got_b; k++) begin
            drive(1, a_id, 3, 1, 5'h1F, 0, 1, 0, 0, 6'h00, 200 + k);
`ifdef ENIGMA_ARB_STARVE_EN
            exp_b = (lost == 8);
`else
            exp_b = 1'b0;
`endif
            step(!exp_b, exp_b);
            if (exp_b) got_b = 1'b1;
            else begin
                lost++;
                a_id++;
            end
        end
        drive(0, 5'h00, 0, 0, 5'h00, 0, 1, 0, 0, 6'h00, 300);
        step(0, 0);
        step(0, 0);
        chk("sb_drained", 128'(sb.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
